// File: rtl/vdp_vram_arbiter_pkg.sv
// Shared types and constants for the VDP VRAM arbiter and its tag FIFO.
package vdp_vram_arbiter_pkg;

    typedef enum logic [1:0] {
        SCREEN  = 2'd0,
        SPRITE  = 2'd1,
        CPU     = 2'd2,
        COMMAND = 2'd3
    } req_id_e;

    localparam int TAG_FIFO_DEPTH  = 4;
    localparam int BOOST_THRESHOLD = 16;
    localparam int TAG_PTR_W       = $clog2(TAG_FIFO_DEPTH);
    localparam int TAG_CNT_W       = TAG_PTR_W + 1;

    function automatic logic [TAG_PTR_W-1:0] tag_ptr_inc(input logic [TAG_PTR_W-1:0] p);
        return (p == TAG_PTR_W'(TAG_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/vdp_vram_tag_fifo.sv
// Small FIFO of requester IDs for reads accepted by VRAM and not yet returned.
module vdp_vram_tag_fifo
    import vdp_vram_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [1:0]           push_data,
    input  logic                 pop,
    output logic [1:0]           pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [TAG_CNT_W-1:0] count
);

    logic [TAG_FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
    logic [TAG_PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_CNT_W-1:0]           count_q, count_d;
    logic                           do_push, do_pop;

    assign full     = (count_q == TAG_CNT_W'(TAG_FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = tag_ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = tag_ptr_inc(rd_ptr_q);
        end
        count_d = count_q + TAG_CNT_W'(do_push) - TAG_CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Fixed-priority VRAM arbiter (screen > sprite > cpu > command) with tagged read return.
// Define VDP_VRAM_CPU_BOOST_EN to lift a starved cpu above sprite after BOOST_THRESHOLD cycles.
module vdp_vram_arbiter
    import vdp_vram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [16:0] screen_mode_vram_address,
    input  logic        screen_mode_vram_valid,
    output logic        screen_mode_vram_ready,
    output logic [31:0] screen_mode_vram_rdata,
    output logic        screen_mode_vram_rdata_en,
    input  logic [16:0] sprite_vram_address,
    input  logic        sprite_vram_valid,
    output logic        sprite_vram_ready,
    output logic [31:0] sprite_vram_rdata,
    output logic        sprite_vram_rdata_en,
    input  logic [16:0] cpu_vram_address,
    input  logic        cpu_vram_valid,
    input  logic        cpu_vram_write,
    input  logic [7:0]  cpu_vram_wdata,
    output logic        cpu_vram_ready,
    output logic [31:0] cpu_vram_rdata,
    output logic        cpu_vram_rdata_en,
    input  logic [16:0] command_vram_address,
    input  logic        command_vram_valid,
    input  logic        command_vram_write,
    input  logic [7:0]  command_vram_wdata,
    output logic        command_vram_ready,
    output logic [31:0] command_vram_rdata,
    output logic        command_vram_rdata_en,
    output logic [16:0] vram_address,
    output logic        vram_valid,
    output logic        vram_write,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ready,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en
);

    logic                 vram_valid_q, vram_valid_d;
    logic                 vram_write_q, vram_write_d;
    logic [16:0]          vram_address_q, vram_address_d;
    logic [7:0]           vram_wdata_q, vram_wdata_d;
    req_id_e              vram_id_q, vram_id_d;
    logic [3:0][31:0]     rdata_q, rdata_d;
    logic [3:0]           rdata_en_q, rdata_en_d;
    logic                 tag_underflow_q, tag_underflow_d;
    logic                 tag_full, tag_empty;
    logic [1:0]           tag_head;
    logic [TAG_CNT_W-1:0] tag_count;
    logic                 accept_rd, rd_ok, grant, cpu_boost;
    req_id_e              win;

    assign vram_valid   = vram_valid_q;
    assign vram_write   = vram_write_q;
    assign vram_address = vram_address_q;
    assign vram_wdata   = vram_wdata_q;

    assign screen_mode_vram_rdata    = rdata_q[SCREEN];
    assign sprite_vram_rdata         = rdata_q[SPRITE];
    assign cpu_vram_rdata            = rdata_q[CPU];
    assign command_vram_rdata        = rdata_q[COMMAND];
    assign screen_mode_vram_rdata_en = rdata_en_q[SCREEN];
    assign sprite_vram_rdata_en      = rdata_en_q[SPRITE];
    assign cpu_vram_rdata_en         = rdata_en_q[CPU];
    assign command_vram_rdata_en     = rdata_en_q[COMMAND];

    // A read sitting in the output register already owns a tag slot, so a new read is
    // only latched if the FIFO can still hold it after the current one is pushed.
    assign accept_rd = vram_valid_q && vram_ready && !vram_write_q;
    assign rd_ok     = !tag_full && ((32'(tag_count) + 32'(accept_rd)) < 32'(TAG_FIFO_DEPTH));

    always_comb begin
        grant = 1'b0;
        win   = SCREEN;
        if (!vram_valid_q || vram_ready) begin
            if (screen_mode_vram_valid && rd_ok) begin
                grant = 1'b1; win = SCREEN;
            end else if (cpu_boost && cpu_vram_valid && (cpu_vram_write || rd_ok)) begin
                grant = 1'b1; win = CPU;
            end else if (sprite_vram_valid && rd_ok) begin
                grant = 1'b1; win = SPRITE;
            end else if (cpu_vram_valid && (cpu_vram_write || rd_ok)) begin
                grant = 1'b1; win = CPU;
            end else if (command_vram_valid && (command_vram_write || rd_ok)) begin
                grant = 1'b1; win = COMMAND;
            end
        end
    end

    assign screen_mode_vram_ready = grant && (win == SCREEN);
    assign sprite_vram_ready      = grant && (win == SPRITE);
    assign cpu_vram_ready         = grant && (win == CPU);
    assign command_vram_ready     = grant && (win == COMMAND);

    always_comb begin
        vram_valid_d   = vram_valid_q && !vram_ready;
        vram_write_d   = vram_write_q;
        vram_address_d = vram_address_q;
        vram_wdata_d   = vram_wdata_q;
        vram_id_d      = vram_id_q;
        if (grant) begin
            vram_valid_d = 1'b1;
            vram_id_d    = win;
            case (win)
                SCREEN: begin
                    vram_address_d = screen_mode_vram_address;
                    vram_write_d   = 1'b0;
                    vram_wdata_d   = 8'h00;
                end
                SPRITE: begin
                    vram_address_d = sprite_vram_address;
                    vram_write_d   = 1'b0;
                    vram_wdata_d   = 8'h00;
                end
                CPU: begin
                    vram_address_d = cpu_vram_address;
                    vram_write_d   = cpu_vram_write;
                    vram_wdata_d   = cpu_vram_write ? cpu_vram_wdata : 8'h00;
                end
                default: begin
                    vram_address_d = command_vram_address;
                    vram_write_d   = command_vram_write;
                    vram_wdata_d   = command_vram_write ? command_vram_wdata : 8'h00;
                end
            endcase
        end
        rdata_d         = rdata_q;
        rdata_en_d      = '0;
        tag_underflow_d = tag_underflow_q || (vram_rdata_en && tag_empty);
        if (vram_rdata_en && !tag_empty) begin
            rdata_d[tag_head]    = vram_rdata;
            rdata_en_d[tag_head] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vram_valid_q    <= 1'b0;
            vram_write_q    <= 1'b0;
            vram_address_q  <= '0;
            vram_wdata_q    <= '0;
            vram_id_q       <= SCREEN;
            rdata_q         <= '0;
            rdata_en_q      <= '0;
            tag_underflow_q <= 1'b0;
        end else begin
            vram_valid_q    <= vram_valid_d;
            vram_write_q    <= vram_write_d;
            vram_address_q  <= vram_address_d;
            vram_wdata_q    <= vram_wdata_d;
            vram_id_q       <= vram_id_d;
            rdata_q         <= rdata_d;
            rdata_en_q      <= rdata_en_d;
            tag_underflow_q <= tag_underflow_d;
        end
    end

`ifdef VDP_VRAM_CPU_BOOST_EN
    logic [4:0] boost_cnt_q, boost_cnt_d;

    assign cpu_boost = (boost_cnt_q >= 5'(BOOST_THRESHOLD));

    // Saturates at the threshold so a long-blocked cpu stays boosted until granted.
    always_comb begin
        boost_cnt_d = boost_cnt_q;
        if (cpu_vram_ready) begin
            boost_cnt_d = '0;
        end else if (cpu_vram_valid && !cpu_boost) begin
            boost_cnt_d = boost_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            boost_cnt_q <= '0;
        end else begin
            boost_cnt_q <= boost_cnt_d;
        end
    end
`else
    assign cpu_boost = 1'b0;
`endif

    vdp_vram_tag_fifo u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept_rd),
        .push_data (vram_id_q),
        .pop       (vram_rdata_en),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter; read returns are checked through a scoreboard queue.
module tb_vdp_vram_arbiter;
    import vdp_vram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] screen_mode_vram_address;
    logic        screen_mode_vram_valid;
    logic        screen_mode_vram_ready;
    logic [31:0] screen_mode_vram_rdata;
    logic        screen_mode_vram_rdata_en;
    logic [16:0] sprite_vram_address;
    logic        sprite_vram_valid;
    logic        sprite_vram_ready;
    logic [31:0] sprite_vram_rdata;
    logic        sprite_vram_rdata_en;
    logic [16:0] cpu_vram_address;
    logic        cpu_vram_valid;
    logic        cpu_vram_write;
    logic [7:0]  cpu_vram_wdata;
    logic        cpu_vram_ready;
    logic [31:0] cpu_vram_rdata;
    logic        cpu_vram_rdata_en;
    logic [16:0] command_vram_address;
    logic        command_vram_valid;
    logic        command_vram_write;
    logic [7:0]  command_vram_wdata;
    logic        command_vram_ready;
    logic [31:0] command_vram_rdata;
    logic        command_vram_rdata_en;
    logic [16:0] vram_address;
    logic        vram_valid;
    logic        vram_write;
    logic [7:0]  vram_wdata;
    logic        vram_ready;
    logic [31:0] vram_rdata;
    logic        vram_rdata_en;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic pend   = 1'b0;

    vdp_vram_arbiter dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .screen_mode_vram_address  (screen_mode_vram_address),
        .screen_mode_vram_valid    (screen_mode_vram_valid),
        .screen_mode_vram_ready    (screen_mode_vram_ready),
        .screen_mode_vram_rdata    (screen_mode_vram_rdata),
        .screen_mode_vram_rdata_en (screen_mode_vram_rdata_en),
        .sprite_vram_address       (sprite_vram_address),
        .sprite_vram_valid         (sprite_vram_valid),
        .sprite_vram_ready         (sprite_vram_ready),
        .sprite_vram_rdata         (sprite_vram_rdata),
        .sprite_vram_rdata_en      (sprite_vram_rdata_en),
        .cpu_vram_address          (cpu_vram_address),
        .cpu_vram_valid            (cpu_vram_valid),
        .cpu_vram_write            (cpu_vram_write),
        .cpu_vram_wdata            (cpu_vram_wdata),
        .cpu_vram_ready            (cpu_vram_ready),
        .cpu_vram_rdata            (cpu_vram_rdata),
        .cpu_vram_rdata_en         (cpu_vram_rdata_en),
        .command_vram_address      (command_vram_address),
        .command_vram_valid        (command_vram_valid),
        .command_vram_write        (command_vram_write),
        .command_vram_wdata        (command_vram_wdata),
        .command_vram_ready        (command_vram_ready),
        .command_vram_rdata        (command_vram_rdata),
        .command_vram_rdata_en     (command_vram_rdata_en),
        .vram_address              (vram_address),
        .vram_valid                (vram_valid),
        .vram_write                (vram_write),
        .vram_wdata                (vram_wdata),
        .vram_ready                (vram_ready),
        .vram_rdata                (vram_rdata),
        .vram_rdata_en             (vram_rdata_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // {screen, sprite, cpu, command}
    function automatic logic [3:0] rdy();
        return {screen_mode_vram_ready, sprite_vram_ready, cpu_vram_ready, command_vram_ready};
    endfunction

    // bit index = requester ID
    function automatic logic [3:0] en_vec();
        return {command_vram_rdata_en, cpu_vram_rdata_en, sprite_vram_rdata_en, screen_mode_vram_rdata_en};
    endfunction

    function automatic logic [31:0] rdata_of(input logic [1:0] id);
        case (id)
            2'd0:    return screen_mode_vram_rdata;
            2'd1:    return sprite_vram_rdata;
            2'd2:    return cpu_vram_rdata;
            default: return command_vram_rdata;
        endcase
    endfunction

    task automatic ret(input logic [1:0] id, input logic [31:0] d);
        vram_rdata_en = 1'b1;
        vram_rdata    = d;
        sb.push_back({id, d});
        nxt();
        vram_rdata_en = 1'b0;
    endtask

    // One boost-phase cycle: the memory model answers each accepted read one cycle later.
    task automatic fcyc(input int k, input logic [3:0] exp_rdy);
        if (pend) begin
            vram_rdata_en = 1'b1;
            vram_rdata    = 32'hB000_0000 + 32'(k);
            sb.push_back({2'd1, 32'hB000_0000 + 32'(k)});
        end else begin
            vram_rdata_en = 1'b0;
        end
        smp();
        chk($sformatf("f_gnt%0d", k), 32'(rdy()), 32'(exp_rdy));
        pend = vram_valid && vram_ready && !vram_write;
        nxt();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && en_vec() != 4'b0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(en_vec()), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_en", 32'(en_vec()), 32'(4'b0001 << e.id));
                chk("rsp_data", rdata_of(e.id), e.data);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        screen_mode_vram_address = '0; screen_mode_vram_valid = 1'b0;
        sprite_vram_address = '0;      sprite_vram_valid = 1'b0;
        cpu_vram_address = '0;  cpu_vram_valid = 1'b0;  cpu_vram_write = 1'b0;  cpu_vram_wdata = '0;
        command_vram_address = '0; command_vram_valid = 1'b0; command_vram_write = 1'b0; command_vram_wdata = '0;
        vram_ready = 1'b0; vram_rdata = '0; vram_rdata_en = 1'b0;
        nxt(); nxt();
        smp();
        chk("rst_valid", 32'(vram_valid), 32'h0);
        chk("rst_addr", 32'(vram_address), 32'h0);
        chk("rst_en", 32'(en_vec()), 32'h0);
        chk("rst_empty", 32'(dut.tag_empty), 32'h1);
        chk("rst_uflow", 32'(dut.tag_underflow_q), 32'h0);
        nxt();
        reset_n = 1'b1;

        // all four requesters at once
        screen_mode_vram_valid = 1'b1; screen_mode_vram_address = 17'h00100;
        sprite_vram_valid = 1'b1;      sprite_vram_address = 17'h00200;
        cpu_vram_valid = 1'b1;         cpu_vram_address = 17'h00300;
        command_vram_valid = 1'b1;     command_vram_address = 17'h00400;
        vram_ready = 1'b1;
        smp(); chk("a_gnt0", 32'(rdy()), 32'h8); chk("a_vld0", 32'(vram_valid), 32'h0);
        nxt(); screen_mode_vram_valid = 1'b0;
        smp(); chk("a_gnt1", 32'(rdy()), 32'h4); chk("a_addr1", 32'(vram_address), 32'h00100);
        nxt(); sprite_vram_valid = 1'b0;
        smp(); chk("a_gnt2", 32'(rdy()), 32'h2); chk("a_addr2", 32'(vram_address), 32'h00200);
        nxt(); cpu_vram_valid = 1'b0;
        smp(); chk("a_gnt3", 32'(rdy()), 32'h1); chk("a_addr3", 32'(vram_address), 32'h00300);
        chk("a_wr3", 32'(vram_write), 32'h0);
        nxt(); command_vram_valid = 1'b0;
        smp(); chk("a_gnt4", 32'(rdy()), 32'h0); chk("a_addr4", 32'(vram_address), 32'h00400);
        nxt();
        smp(); chk("a_vld5", 32'(vram_valid), 32'h0); chk("a_full", 32'(dut.tag_full), 32'h1);
        nxt();
        for (int i = 0; i < 4; i++) ret(2'(i), 32'hA0A0_0000 + 32'(i));
        nxt(); nxt();
        chk("a_sb", 32'(sb.size()), 32'h0);

        // held output register
        cpu_vram_valid = 1'b1; cpu_vram_address = 17'h1ABCD; cpu_vram_write = 1'b0; vram_ready = 1'b0;
        smp(); chk("b_gnt0", 32'(rdy()), 32'h2);
        nxt(); cpu_vram_valid = 1'b0; sprite_vram_valid = 1'b1; sprite_vram_address = 17'h00777;
        for (int k = 1; k < 4; k++) begin
            smp();
            chk($sformatf("b_addr%0d", k), 32'(vram_address), 32'h1ABCD);
            chk($sformatf("b_vld%0d", k), 32'(vram_valid), 32'h1);
            chk($sformatf("b_gnt%0d", k), 32'(rdy()), 32'h0);
            nxt();
        end
        sprite_vram_valid = 1'b0; vram_ready = 1'b1;
        smp(); chk("b_addr4", 32'(vram_address), 32'h1ABCD);
        nxt();
        smp(); chk("b_vld5", 32'(vram_valid), 32'h0);
        nxt();
        ret(2'd2, 32'hCAFE_0001);
        nxt(); nxt();

        // tag FIFO full: reads blocked, writes pass
        sprite_vram_valid = 1'b1; sprite_vram_address = 17'h00A00;
        for (int k = 0; k < 4; k++) begin
            smp(); chk($sformatf("c_gnt%0d", k), 32'(rdy()), 32'h4);
            nxt(); sprite_vram_address = sprite_vram_address + 17'h1;
        end
        smp(); chk("c_blk4", 32'(rdy()), 32'h0);
        nxt();
        cpu_vram_valid = 1'b1; cpu_vram_write = 1'b1; cpu_vram_address = 17'h00010; cpu_vram_wdata = 8'h5A;
        smp(); chk("c_full", 32'(dut.tag_full), 32'h1); chk("c_wgnt", 32'(rdy()), 32'h2);
        nxt(); cpu_vram_valid = 1'b0; cpu_vram_write = 1'b0;
        smp();
        chk("c_wr", 32'(vram_write), 32'h1); chk("c_waddr", 32'(vram_address), 32'h00010);
        chk("c_wdata", 32'(vram_wdata), 32'h5A); chk("c_blk6", 32'(rdy()), 32'h0);
        nxt();
        vram_rdata_en = 1'b1; vram_rdata = 32'h1122_3344; sb.push_back({2'd1, 32'h1122_3344});
        smp(); chk("c_blk7", 32'(rdy()), 32'h0); chk("c_en_early", 32'(sprite_vram_rdata_en), 32'h0);
        nxt(); vram_rdata_en = 1'b0;
        smp();
        chk("c_en", 32'(sprite_vram_rdata_en), 32'h1); chk("c_rdata", sprite_vram_rdata, 32'h1122_3344);
        chk("c_gnt5", 32'(rdy()), 32'h4);
        nxt(); sprite_vram_valid = 1'b0;
        smp(); chk("c_en_off", 32'(sprite_vram_rdata_en), 32'h0); chk("c_vld5", 32'(vram_valid), 32'h1);
        nxt();
        for (int i = 0; i < 4; i++) ret(2'd1, 32'h5500_0000 + 32'(i));
        nxt(); nxt();

        // in-order routing, read data forced to zero wdata
        screen_mode_vram_valid = 1'b1; screen_mode_vram_address = 17'h01000;
        cpu_vram_valid = 1'b1; cpu_vram_address = 17'h02000; cpu_vram_write = 1'b0; cpu_vram_wdata = 8'hFF;
        smp(); chk("d_gnt0", 32'(rdy()), 32'h8);
        nxt(); screen_mode_vram_valid = 1'b0;
        smp(); chk("d_gnt1", 32'(rdy()), 32'h2); chk("d_swr", 32'(vram_write), 32'h0);
        nxt(); cpu_vram_valid = 1'b0;
        smp(); chk("d_addr", 32'(vram_address), 32'h02000); chk("d_wdata", 32'(vram_wdata), 32'h0);
        nxt();
        ret(2'd0, 32'hAAAA_5555);
        ret(2'd2, 32'h1234_5678);
        nxt();
        smp();
        chk("d_scr_hold", screen_mode_vram_rdata, 32'hAAAA_5555);
        chk("d_cpu", cpu_vram_rdata, 32'h1234_5678);
        chk("d_cmd_hold", command_vram_rdata, 32'hA0A0_0003);
        chk("d_sb", 32'(sb.size()), 32'h0);
        nxt();

        // starvation: sprite held, cpu write pending
        sprite_vram_valid = 1'b1; sprite_vram_address = 17'h00B00;
        cpu_vram_valid = 1'b1; cpu_vram_write = 1'b1; cpu_vram_address = 17'h00020; cpu_vram_wdata = 8'hA5;
        pend = 1'b0;
        for (int k = 0; k < 20; k++) begin
`ifdef VDP_VRAM_CPU_BOOST_EN
            fcyc(k, (k == 16) ? 4'h2 : 4'h4);
            if (k == 16) begin
                cpu_vram_valid = 1'b0; cpu_vram_write = 1'b0;
            end
`else
            fcyc(k, 4'h4);
`endif
        end
        sprite_vram_valid = 1'b0; cpu_vram_valid = 1'b0; cpu_vram_write = 1'b0;
        for (int k = 20; k < 23; k++) fcyc(k, 4'h0);
        vram_rdata_en = 1'b0;
        nxt(); nxt();
        chk("f_sb", 32'(sb.size()), 32'h0);

        // reset with reads outstanding and one in flight
        screen_mode_vram_valid = 1'b1; screen_mode_vram_address = 17'h03000;
        smp(); chk("e_gnt0", 32'(rdy()), 32'h8);
        nxt(); screen_mode_vram_valid = 1'b0; sprite_vram_valid = 1'b1; sprite_vram_address = 17'h03100;
        smp(); chk("e_gnt1", 32'(rdy()), 32'h4);
        nxt(); sprite_vram_valid = 1'b0; cpu_vram_valid = 1'b1; cpu_vram_address = 17'h03200;
        smp(); chk("e_gnt2", 32'(rdy()), 32'h2);
        nxt(); cpu_vram_valid = 1'b0; vram_ready = 1'b0;
        smp(); chk("e_inflight", 32'(vram_valid), 32'h1);
        nxt(); reset_n = 1'b0;
        nxt(); reset_n = 1'b1;
        smp();
        chk("e_valid", 32'(vram_valid), 32'h0); chk("e_addr", 32'(vram_address), 32'h0);
        chk("e_write", 32'(vram_write), 32'h0); chk("e_wdata", 32'(vram_wdata), 32'h0);
        chk("e_scr_rd", screen_mode_vram_rdata, 32'h0); chk("e_spr_rd", sprite_vram_rdata, 32'h0);
        chk("e_cpu_rd", cpu_vram_rdata, 32'h0); chk("e_cmd_rd", command_vram_rdata, 32'h0);
        chk("e_en", 32'(en_vec()), 32'h0); chk("e_empty", 32'(dut.tag_empty), 32'h1);
        chk("e_uflow0", 32'(dut.tag_underflow_q), 32'h0);
        nxt();
        vram_rdata_en = 1'b1; vram_rdata = 32'hDEAD_BEEF;
        nxt(); vram_rdata_en = 1'b0;
        smp();
        chk("e_no_en", 32'(en_vec()), 32'h0); chk("e_uflow1", 32'(dut.tag_underflow_q), 32'h1);
        chk("e_scr_still0", screen_mode_vram_rdata, 32'h0);
        nxt();
        reset_n = 1'b0;
        nxt(); reset_n = 1'b1;
        smp(); chk("e_uflow_clr", 32'(dut.tag_underflow_q), 32'h0);
        nxt();
        chk("end_sb", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
